// File: rtl/modulus_lut_pkg.sv
// rtl/modulus_lut_pkg.sv - shared constants and loader state type for the modulus LUT loader
package modulus_lut_pkg;

  localparam int NONUPLE_BITS = 9;
  localparam int NUM_NONUPLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/modulus_lut_beat_packer.sv
// rtl/modulus_lut_beat_packer.sv - shifts DATA_W beats into one little-endian MODULUS_WIDTH entry
module modulus_lut_beat_packer
  import modulus_lut_pkg::*;
#(
  parameter int MODULUS_WIDTH = 1024,
  parameter int DATA_W        = 64
) (
  input  logic                     clk_phase,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     accept,
  input  logic [DATA_W-1:0]        beat,
  output logic                     entry_complete,
  output logic [MODULUS_WIDTH-1:0] entry_word
);

  localparam int BEATS  = MODULUS_WIDTH / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W-1:0]               beat_cnt_q, beat_cnt_d;
  logic [MODULUS_WIDTH-DATA_W-1:0] shreg_q, shreg_d;

  // New beats enter at the top, so the first beat of an entry drifts down to the low slice.
  assign entry_word     = {beat, shreg_q};
  assign entry_complete = accept && (beat_cnt_q == BEAT_W'(BEATS - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    shreg_d    = shreg_q;
    if (clear) begin
      beat_cnt_d = '0;
      shreg_d    = '0;
    end else if (accept) begin
      shreg_d    = entry_word[MODULUS_WIDTH-1:DATA_W];
      beat_cnt_d = entry_complete ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

endmodule

// File: rtl/modulus_lut_loader.sv
// rtl/modulus_lut_loader.sv - streams beats into NUM_TABLES x TABLE_DEPTH modulus entries
// Optional MODULUS_LUT_LOADER_CHECKSUM_EN adds an XOR checksum of accepted beats.
module modulus_lut_loader
  import modulus_lut_pkg::*;
#(
  parameter int MODULUS_WIDTH = 1024,
  parameter int DATA_W        = 64,
  parameter int NUM_TABLES    = 4,
  parameter int TABLE_DEPTH   = 512,
  localparam int ADDR_W       = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
  input  logic                     clk_phase,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  output logic [NUM_TABLES-1:0]    wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [MODULUS_WIDTH-1:0] wr_data,
  output logic                     busy,
  output logic                     done
`ifdef MODULUS_LUT_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]        checksum
`endif
);

  localparam int TBL_W = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;

  loader_state_e              state_q, state_d;
  logic [ADDR_W-1:0]          entry_q, entry_d;
  logic [TBL_W-1:0]           table_q, table_d;
  logic [NUM_TABLES-1:0]      wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [MODULUS_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                       done_q, done_d;
  logic                       accept, start_load, entry_complete, last_entry;
  logic [MODULUS_WIDTH-1:0]   entry_word;

  assign start_load = start && (state_q != LOAD);
  assign accept     = s_valid && (state_q == LOAD);
  assign last_entry = (entry_q == ADDR_W'(TABLE_DEPTH - 1)) && (table_q == TBL_W'(NUM_TABLES - 1));

  modulus_lut_beat_packer #(
    .MODULUS_WIDTH (MODULUS_WIDTH),
    .DATA_W        (DATA_W)
  ) u_packer (
    .clk_phase      (clk_phase),
    .rst_n          (rst_n),
    .clear          (start_load),
    .accept         (accept),
    .beat           (s_data),
    .entry_complete (entry_complete),
    .entry_word     (entry_word)
  );

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    table_d   = table_q;
    done_d    = done_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          entry_d = '0;
          table_d = '0;
          done_d  = 1'b0;
        end else if (state_q == DONE) begin
          // done trails the final write strobe by one cycle
          done_d = 1'b1;
        end
      end
      LOAD: begin
        if (entry_complete) begin
          wr_en_d   = NUM_TABLES'(1) << table_q;
          wr_addr_d = entry_q;
          wr_data_d = entry_word;
          if (entry_q == ADDR_W'(TABLE_DEPTH - 1)) begin
            entry_d = '0;
            table_d = (table_q == TBL_W'(NUM_TABLES - 1)) ? '0 : table_q + 1'b1;
          end else begin
            entry_d = entry_q + 1'b1;
          end
          if (last_entry) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      entry_q   <= '0;
      table_q   <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      table_q   <= table_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q == LOAD);
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;

`ifdef MODULUS_LUT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk_phase or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (start_load) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q ^ s_data;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
